// File: rtl/gmii_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_pkg
//  Description : Shared types and constants for the GMII receive deframer:
//                FSM state encoding, Ethernet preamble/SFD bytes and the
//                CRC-32 polynomial, seed and good-frame residue.
//  Revision    : 1.0  initial release
// ============================================================================
package gmii_rx_pkg;

    // Deframer states; 2-bit encoding is fixed so the register width is explicit
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value left behind after running data plus a correct FCS
    // through the CRC without the final inversion
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage : gmii_rx_pkg
`default_nettype wire

// File: rtl/eth_crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : eth_crc32_d8
//  Description : Combinational next-state function of the reflected Ethernet
//                CRC-32 for one 8-bit data byte (LSB first). No inversion is
//                applied; the caller owns seeding and residue checking.
//  Revision    : 1.0  initial release
// ============================================================================
module eth_crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    // Eight serial shift steps unrolled into a single combinational cone
    always_comb begin
        w_crc = i_crc ^ {24'h000000, i_data};
        for (int b = 0; b < 8; b++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY) : (w_crc >> 1);
        end
        o_crc = w_crc;
    end

endmodule : eth_crc32_d8
`default_nettype wire

// File: rtl/gmii_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_deframer
//  Description : Strips preamble/SFD from a GMII receive stream, removes the
//                FCS through a 5-byte delay line, checks CRC-32 and length,
//                and emits an AXI-Stream style byte stream (no back-pressure)
//                with tuser marking bad frames on the tlast beat.
//  Options     : define GMII_RX_DEFRAMER_STATS_EN to build the per-frame
//                status pulse outputs; otherwise those ports read 0.
//  Revision    : 1.0  initial release
// ============================================================================
module gmii_rx_deframer
    import gmii_rx_pkg::*;
#(
    parameter int p_MIN_FRAME_LEN = 64,
    parameter int p_MAX_FRAME_LEN = 1518
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clk_en,
    input  logic [7:0] i_gmii_rxd,
    input  logic       i_gmii_rx_dv,
    input  logic       i_gmii_rx_er,
    output logic [7:0] o_m_axis_tdata,
    output logic       o_m_axis_tvalid,
    output logic       o_m_axis_tlast,
    output logic       o_m_axis_tuser,
    output logic       o_stat_frame_good,
    output logic       o_stat_bad_fcs,
    output logic       o_stat_bad_len,
    output logic       o_stat_rx_err
);

    localparam logic [15:0] c_MIN_LEN  = 16'(p_MIN_FRAME_LEN);
    localparam logic [15:0] c_MAX_LEN  = 16'(p_MAX_FRAME_LEN);
    localparam logic [15:0] c_OVR_LEN  = 16'(p_MAX_FRAME_LEN + 1);
    localparam logic [2:0]  c_DLY_FULL = 3'd5;
    localparam logic [2:0]  c_PRE_MAX  = 3'd7;

    rx_state_t       r_state_q,   w_state_d;
    logic [2:0]      r_pre_cnt_q, w_pre_cnt_d;
    logic [15:0]     r_cnt_q,     w_cnt_d;
    logic [31:0]     r_crc_q,     w_crc_d;
    logic [4:0][7:0] r_dly_q,     w_dly_d;
    logic [2:0]      r_fill_q,    w_fill_d;
    logic            r_err_q,     w_err_d;
    logic            r_armed_q,   w_armed_d;
    logic [7:0]      r_tdata_q,   w_tdata_d;
    logic            r_tvalid_q,  w_tvalid_d;
    logic            r_tlast_q,   w_tlast_d;
    logic            r_tuser_q,   w_tuser_d;

    logic [31:0]     w_crc_next;
    logic            w_len_bad;
    logic            w_fcs_bad;

    eth_crc32_d8 u_crc (
        .i_crc  (r_crc_q),
        .i_data (i_gmii_rxd),
        .o_crc  (w_crc_next)
    );

    // Frame verdict components, evaluated when rx_dv falls in PAYLOAD; the
    // upper bound catches a frame exactly one byte too long
    assign w_len_bad = (r_cnt_q < c_MIN_LEN) || (r_cnt_q > c_MAX_LEN);
    assign w_fcs_bad = (r_crc_q != CRC32_RESIDUE);

    // Next-state, datapath and stream-beat decode; nothing moves without i_clk_en
    always_comb begin
        w_state_d   = r_state_q;
        w_pre_cnt_d = r_pre_cnt_q;
        w_cnt_d     = r_cnt_q;
        w_crc_d     = r_crc_q;
        w_dly_d     = r_dly_q;
        w_fill_d    = r_fill_q;
        w_err_d     = r_err_q;
        w_armed_d   = r_armed_q;
        w_tdata_d   = r_tdata_q;
        w_tvalid_d  = 1'b0;
        w_tlast_d   = 1'b0;
        w_tuser_d   = 1'b0;

        if (i_clk_en) begin
            // First enabled cycle after reset may land mid-frame; refuse to
            // start a frame until rx_dv has been seen in that cycle
            w_armed_d = 1'b1;
            case (r_state_q)
                ST_IDLE: begin
                    if (i_gmii_rx_dv) begin
                        if (r_armed_q && (i_gmii_rxd == ETH_PREAMBLE)) begin
                            w_state_d   = ST_PREAMBLE;
                            w_pre_cnt_d = 3'd1;
                        end else begin
                            w_state_d = ST_DROP;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!i_gmii_rx_dv) begin
                        w_state_d = ST_IDLE;
                    end else if (i_gmii_rxd == ETH_PREAMBLE) begin
                        if (r_pre_cnt_q == c_PRE_MAX) begin
                            w_state_d = ST_DROP;
                        end else begin
                            w_pre_cnt_d = r_pre_cnt_q + 3'd1;
                        end
                    end else if (i_gmii_rxd == ETH_SFD) begin
                        w_state_d = ST_PAYLOAD;
                        w_crc_d   = CRC32_INIT;
                        w_cnt_d   = 16'd0;
                        w_fill_d  = 3'd0;
                        w_err_d   = 1'b0;
                    end else begin
                        w_state_d = ST_DROP;
                    end
                end
                ST_PAYLOAD: begin
                    if (i_gmii_rx_dv) begin
                        w_crc_d = w_crc_next;
                        w_dly_d = {r_dly_q[3:0], i_gmii_rxd};
                        w_cnt_d = (r_cnt_q == 16'hFFFF) ? r_cnt_q : r_cnt_q + 16'd1;
                        w_err_d = r_err_q | i_gmii_rx_er;
                        if (r_fill_q != c_DLY_FULL) begin
                            w_fill_d = r_fill_q + 3'd1;
                        end else begin
                            w_tvalid_d = 1'b1;
                            w_tdata_d  = r_dly_q[4];
                            // Over-length: close the stream now, flag it bad
                            if (r_cnt_q == c_OVR_LEN) begin
                                w_tlast_d = 1'b1;
                                w_tuser_d = 1'b1;
                                w_state_d = ST_DROP;
                            end
                        end
                    end else begin
                        // Oldest delay byte is the last data byte; the four
                        // younger ones are the FCS and are discarded
                        w_state_d = ST_IDLE;
                        if (r_fill_q == c_DLY_FULL) begin
                            w_tvalid_d = 1'b1;
                            w_tdata_d  = r_dly_q[4];
                            w_tlast_d  = 1'b1;
                            w_tuser_d  = r_err_q | w_len_bad | w_fcs_bad;
                        end
                    end
                end
                ST_DROP: begin
                    if (!i_gmii_rx_dv) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state_q   <= ST_IDLE;
            r_pre_cnt_q <= 3'd0;
            r_cnt_q     <= 16'd0;
            r_crc_q     <= CRC32_INIT;
            r_dly_q     <= '0;
            r_fill_q    <= 3'd0;
            r_err_q     <= 1'b0;
            r_armed_q   <= 1'b0;
            r_tdata_q   <= 8'h00;
            r_tvalid_q  <= 1'b0;
            r_tlast_q   <= 1'b0;
            r_tuser_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pre_cnt_q <= w_pre_cnt_d;
            r_cnt_q     <= w_cnt_d;
            r_crc_q     <= w_crc_d;
            r_dly_q     <= w_dly_d;
            r_fill_q    <= w_fill_d;
            r_err_q     <= w_err_d;
            r_armed_q   <= w_armed_d;
            r_tdata_q   <= w_tdata_d;
            r_tvalid_q  <= w_tvalid_d;
            r_tlast_q   <= w_tlast_d;
            r_tuser_q   <= w_tuser_d;
        end
    end

    assign o_m_axis_tdata  = r_tdata_q;
    assign o_m_axis_tvalid = r_tvalid_q;
    assign o_m_axis_tlast  = r_tlast_q;
    assign o_m_axis_tuser  = r_tuser_q;

`ifdef GMII_RX_DEFRAMER_STATS_EN
    logic w_good_d, w_bad_fcs_d, w_bad_len_d, w_rx_err_d;
    logic r_good_q, r_bad_fcs_q, r_bad_len_q, r_rx_err_q;

    // One status event per frame end; rx_err outranks length outranks FCS
    always_comb begin
        w_good_d    = 1'b0;
        w_bad_fcs_d = 1'b0;
        w_bad_len_d = 1'b0;
        w_rx_err_d  = 1'b0;
        if (i_clk_en && (r_state_q == ST_PAYLOAD)) begin
            if (i_gmii_rx_dv) begin
                w_bad_len_d = (r_fill_q == c_DLY_FULL) && (r_cnt_q == c_OVR_LEN);
            end else if (r_fill_q != c_DLY_FULL) begin
                w_bad_len_d = 1'b1;
            end else if (r_err_q) begin
                w_rx_err_d = 1'b1;
            end else if (w_len_bad) begin
                w_bad_len_d = 1'b1;
            end else if (w_fcs_bad) begin
                w_bad_fcs_d = 1'b1;
            end else begin
                w_good_d = 1'b1;
            end
        end
    end

    // Status pulse registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_good_q    <= 1'b0;
            r_bad_fcs_q <= 1'b0;
            r_bad_len_q <= 1'b0;
            r_rx_err_q  <= 1'b0;
        end else begin
            r_good_q    <= w_good_d;
            r_bad_fcs_q <= w_bad_fcs_d;
            r_bad_len_q <= w_bad_len_d;
            r_rx_err_q  <= w_rx_err_d;
        end
    end

    assign o_stat_frame_good = r_good_q;
    assign o_stat_bad_fcs    = r_bad_fcs_q;
    assign o_stat_bad_len    = r_bad_len_q;
    assign o_stat_rx_err     = r_rx_err_q;
`else
    assign o_stat_frame_good = 1'b0;
    assign o_stat_bad_fcs    = 1'b0;
    assign o_stat_bad_len    = 1'b0;
    assign o_stat_rx_err     = 1'b0;
`endif

endmodule : gmii_rx_deframer
`default_nettype wire
